// File: rtl/gcd_datapath.sv
// GCD datapath: operand registers, subtract/swap mux, compare flags, result capture,
// iteration counting with saturation, and sticky zero-operand / timeout error flags.
module gcd_datapath #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ITER_W   = 16,
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              load_A,
    input  logic              load_B,
    input  logic              s_in1,
    input  logic              s_in2,
    input  logic              s_in3,
    input  logic              done,
    output logic              EQ,
    output logic              LT,
    output logic              GT,
    output logic [WIDTH-1:0]  o_result,
    output logic              o_result_valid,
    output logic [ITER_W-1:0] o_iter_count,
    output logic              o_zero_err,
    output logic              o_timeout
);

    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] mux_out;
    logic             mux_valid;
    logic             done_q;
    logic             start;
    logic             sub_sel;
    logic             step;
    logic             done_rise;

    // Shared register input: operand load beats B-A beats A-B; no select means hold.
    always_comb begin
        mux_out   = a;
        mux_valid = 1'b1;
        if (s_in3) begin
            mux_out = i_data;
        end else if (s_in1) begin
            mux_out = b - a;
        end else if (s_in2) begin
            mux_out = a - b;
        end else begin
            mux_valid = 1'b0;
        end
    end

    assign start     = s_in3 & load_A;
    assign sub_sel   = ~s_in3 & (s_in1 | s_in2);
    assign step      = sub_sel & (load_A | load_B);
    assign done_rise = done & ~done_q;

    assign EQ = (a == b);
    assign LT = (a < b);
    assign GT = (a > b);

    // Operand registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a <= '0;
            b <= '0;
        end else begin
            if (load_A && mux_valid) a <= mux_out;
            if (load_B && mux_valid) b <= mux_out;
        end
    end

    // Per-computation status; a new operand A load restarts it and overrides a done edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            done_q         <= 1'b0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_iter_count   <= '0;
            o_zero_err     <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            done_q <= done;
            if (start) begin
                o_result_valid <= 1'b0;
                o_iter_count   <= '0;
                o_zero_err     <= 1'b0;
                o_timeout      <= 1'b0;
            end else begin
                if (done_rise) begin
                    o_result       <= a;
                    o_result_valid <= 1'b1;
                end
                if (step && (o_iter_count != ITER_MAX)) begin
                    o_iter_count <= o_iter_count + ITER_W'(1);
                    if ((o_iter_count + ITER_W'(1)) == ITER_MAX) o_timeout <= 1'b1;
                end
                // Zero operand never converges under subtraction
                if (sub_sel && ((a == '0) || (b == '0))) o_zero_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gcd_datapath.sv
// Self-checking bench for gcd_datapath: directed vector table plus hand-written
// sequences for timeout, load/done collision and asynchronous reset.
module tb_gcd_datapath;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ITER_W = 16;

    logic              clk;
    logic              rst_n;
    logic [WIDTH-1:0]  data;
    logic              load_a, load_b, s1, s2, s3, dn;

    logic              eq, lt, gt, valid, zero_err, timeout;
    logic [WIDTH-1:0]  result;
    logic [ITER_W-1:0] iter;

    logic              eq4, lt4, gt4, valid4, zero_err4, timeout4;
    logic [WIDTH-1:0]  result4;
    logic [ITER_W-1:0] iter4;

    int checks = 0;
    int errors = 0;

    gcd_datapath #(.WIDTH(WIDTH), .ITER_W(ITER_W), .MAX_ITER(65535)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data),
        .load_A(load_a), .load_B(load_b), .s_in1(s1), .s_in2(s2), .s_in3(s3), .done(dn),
        .EQ(eq), .LT(lt), .GT(gt), .o_result(result), .o_result_valid(valid),
        .o_iter_count(iter), .o_zero_err(zero_err), .o_timeout(timeout)
    );

    gcd_datapath #(.WIDTH(WIDTH), .ITER_W(ITER_W), .MAX_ITER(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data),
        .load_A(load_a), .load_B(load_b), .s_in1(s1), .s_in2(s2), .s_in3(s3), .done(dn),
        .EQ(eq4), .LT(lt4), .GT(gt4), .o_result(result4), .o_result_valid(valid4),
        .o_iter_count(iter4), .o_zero_err(zero_err4), .o_timeout(timeout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]  data;
        logic              la, lb, s1, s2, s3, dn;
        logic              eq, lt, gt;
        logic [WIDTH-1:0]  res;
        logic              val;
        logic [ITER_W-1:0] iter;
        logic              zero;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int d, bit la, bit lb, bit s1_, bit s2_, bit s3_, bit dn_,
                                bit eq_, bit lt_, bit gt_, int res, bit val, int it, bit zero);
        vec_t v;
        v.data = WIDTH'(d);
        v.la = la; v.lb = lb; v.s1 = s1_; v.s2 = s2_; v.s3 = s3_; v.dn = dn_;
        v.eq = eq_; v.lt = lt_; v.gt = gt_;
        v.res = WIDTH'(res); v.val = val; v.iter = ITER_W'(it); v.zero = zero;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input bit la, input bit lb, input bit s1_, input bit s2_,
                         input bit s3_, input bit dn_);
        @(negedge clk);
        data = WIDTH'(d); load_a = la; load_b = lb; s1 = s1_; s2 = s2_; s3 = s3_; dn = dn_;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " EQ"}, int'(eq), 1);
        chk({tag, " LT"}, int'(lt), 0);
        chk({tag, " GT"}, int'(gt), 0);
        chk({tag, " result"}, int'(result), 0);
        chk({tag, " valid"}, int'(valid), 0);
        chk({tag, " iter"}, int'(iter), 0);
        chk({tag, " zero_err"}, int'(zero_err), 0);
        chk({tag, " timeout"}, int'(timeout), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        data = '0; load_a = 0; load_b = 0; s1 = 0; s2 = 0; s3 = 0; dn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state("reset");

        //             data la lb s1 s2 s3 dn  eq lt gt res val it zero
        vecs.push_back(mk(48, 1, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0)); // A=48 B=0
        vecs.push_back(mk(18, 0, 1, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0)); // B=18
        vecs.push_back(mk(0,  1, 0, 0, 1, 0, 0,  0, 0, 1, 0, 0, 1, 0)); // A=30
        vecs.push_back(mk(0,  1, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 2, 0)); // A=12
        vecs.push_back(mk(0,  0, 1, 1, 0, 0, 0,  0, 0, 1, 0, 0, 3, 0)); // B=6
        vecs.push_back(mk(0,  1, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 4, 0)); // A=6
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 1,  1, 0, 0, 6, 1, 4, 0)); // done edge
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 1,  1, 0, 0, 6, 1, 4, 0)); // done held
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0,  1, 0, 0, 6, 1, 4, 0));
        vecs.push_back(mk(7,  1, 0, 0, 0, 1, 0,  0, 0, 1, 6, 0, 0, 0)); // A=7 B=6
        vecs.push_back(mk(7,  0, 1, 0, 0, 1, 0,  1, 0, 0, 6, 0, 0, 0)); // B=7
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 1,  1, 0, 0, 7, 1, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0,  1, 0, 0, 7, 1, 0, 0));
        vecs.push_back(mk(0,  1, 0, 0, 0, 1, 0,  0, 1, 0, 7, 0, 0, 0)); // A=0 B=7
        vecs.push_back(mk(5,  0, 1, 0, 0, 1, 0,  0, 1, 0, 7, 0, 0, 0)); // B=5
        vecs.push_back(mk(0,  0, 1, 1, 0, 0, 0,  0, 1, 0, 7, 0, 1, 1)); // B=5-0
        vecs.push_back(mk(0,  0, 1, 1, 0, 0, 0,  0, 1, 0, 7, 0, 2, 1));
        vecs.push_back(mk(0,  1, 0, 0, 0, 0, 0,  0, 1, 0, 7, 0, 2, 1)); // load, no select: hold

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(int'(vecs[i].data), vecs[i].la, vecs[i].lb, vecs[i].s1, vecs[i].s2,
                  vecs[i].s3, vecs[i].dn);
            chk({t, " EQ"}, int'(eq), int'(vecs[i].eq));
            chk({t, " LT"}, int'(lt), int'(vecs[i].lt));
            chk({t, " GT"}, int'(gt), int'(vecs[i].gt));
            chk({t, " result"}, int'(result), int'(vecs[i].res));
            chk({t, " valid"}, int'(valid), int'(vecs[i].val));
            chk({t, " iter"}, int'(iter), int'(vecs[i].iter));
            chk({t, " zero_err"}, int'(zero_err), int'(vecs[i].zero));
        end

        // Timeout: MAX_ITER=4 instance, A=1 B=100, five B-A steps
        drive(1, 1, 0, 0, 0, 1, 0);
        drive(100, 0, 1, 0, 0, 1, 0);
        chk("to load zero_err", int'(zero_err4), 0);
        chk("to load timeout", int'(timeout4), 0);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 1, 1, 0, 0, 0);
            chk($sformatf("to step%0d iter4", k), int'(iter4), (k > 4) ? 4 : k);
            chk($sformatf("to step%0d timeout4", k), int'(timeout4), (k >= 4) ? 1 : 0);
        end
        chk("to LT after B=95", int'(lt4), 1);
        chk("to wide iter", int'(iter), 5);
        chk("to wide timeout", int'(timeout), 0);

        // Operand load collides with done rising edge: load wins
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(9, 1, 0, 0, 0, 1, 1);
        chk("collide valid", int'(valid), 0);
        chk("collide result kept", int'(result), 7);
        chk("collide iter", int'(iter), 0);
        chk("collide timeout4", int'(timeout4), 0);
        chk("collide LT (A=9 B=95)", int'(lt), 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("done held no edge valid", int'(valid), 0);

        // Asynchronous reset mid-computation
        drive(0, 0, 1, 1, 0, 0, 0);
        chk("pre-reset iter", int'(iter), 1);
        @(negedge clk);
        data = '0; load_a = 0; load_b = 0; s1 = 0; s2 = 0; s3 = 0; dn = 0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset EQ", int'(eq), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_datapath.md
Name: gcd_datapath

Overview:
- Datapath slice that sits directly downstream of the GCD controller FSM. It consumes load_A, load_B, s_in1, s_in2, s_in3 and done, and returns the EQ/LT/GT compare flags to it.
- Holds operand registers A and B, performs the subtract-and-swap arithmetic, and captures the final GCD into a result register.
- Tracks iteration count and flags degenerate operands (zero) and runaway computation (timeout) so the system can abort cleanly.

Parameters:
WIDTH, 16, operand / result bit width
ITER_W, 16, width of iteration counter
MAX_ITER, 65535, iteration count at which o_timeout asserts (must fit ITER_W)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_data  input  WIDTH  operand bus; A loaded, then B, from this bus
load_A  input  1  write enable for register A
load_B  input  1  write enable for register B
s_in1  input  1  select B−A as subtractor result
s_in2  input  1  select A−B as subtractor result
s_in3  input  1  select i_data as register input (operand load)
done  input  1  controller reports computation complete
EQ  output  1  A == B (combinational from registers)
LT  output  1  A < B (combinational)
GT  output  1  A > B (combinational)
o_result  output  WIDTH  captured GCD
o_result_valid  output  1  o_result holds a valid GCD
o_iter_count  output  ITER_W  subtraction steps in current computation
o_zero_err  output  1  sticky: A or B was zero during compute
o_timeout  output  1  sticky: o_iter_count reached MAX_ITER

Behaviour:
- Reset (async, i_rst_n=0): A=0, B=0, o_result=0, o_result_valid=0, o_iter_count=0, o_zero_err=0, o_timeout=0, done-edge register=0. After reset A==B, so EQ=1, LT=0, GT=0.
- Register input mux, priority order:
  - s_in3=1 → i_data.
  - else s_in1=1 → B−A.
  - else s_in2=1 → A−B.
  - else register holds, even when its load_* is asserted.
- Subtraction is unsigned, WIDTH bits, modulo 2^WIDTH. The controller guarantees a non-negative result (LT→B−A, GT→A−B).
- A updates on load_A; B updates on load_B. Both load on the same cycle with the shared mux output. The controller never does this, but behaviour is defined.
- EQ/LT/GT are pure combinational from the A/B registers, zero-latency, exactly one asserted at all times.
- Operand load (s_in3=1 with load_A=1) starts a new computation:
  - o_result_valid←0, o_iter_count←0, o_zero_err←0, o_timeout←0.
  - o_result is retained.
- Iteration counter:
  - Increments by 1 on each cycle with s_in3=0 and (s_in1 or s_in2) and (load_A or load_B).
  - Saturates at MAX_ITER.
  - o_timeout sets on the cycle the counter becomes MAX_ITER.
- Zero error: o_zero_err sets on any cycle with s_in3=0, (s_in1|s_in2)=1, and (A==0 or B==0). Sticky until the next operand load or reset. This condition never converges; system logic uses the flag to abort.
- Result capture:
  - On the rising edge of done (done=1, registered done=0): o_result←A, o_result_valid←1, one cycle after done first asserts.
  - Held high while done stays high.
  - A second done edge without an intervening operand load recaptures the same A.
- Operand load and done edge in the same cycle: load wins; valid stays 0.
- Reset mid-computation: all state is cleared immediately, with no partial result retained.

Test Plan:
- Reset then release → EQ=1, o_result=0, o_result_valid=0, all flags 0.
- Load A=48 (s_in3,load_A), B=18 (s_in3,load_B), then drive LT/GT steps per flags → sequence A/B: 48/18, 30/18, 12/18, 12/6, 6/6. EQ=1 after 4 steps, o_iter_count=4. Done pulse → o_result=6 and o_result_valid=1 on the next cycle.
- A=7, B=7 → EQ=1 immediately, iter=0, done → o_result=7.
- A=0, B=5 with LT steps → o_zero_err=1 after first step, B stays 5, EQ never asserts.
- MAX_ITER=4, A=1, B=100, repeated LT steps → o_timeout=1 when iter=4, counter holds 4.
- Operand load asserted in the same cycle as the done rising edge → o_result_valid stays 0, A=i_data; assert i_rst_n=0 mid-computation → all outputs return to reset values asynchronously.
